// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: two-master round-robin arbiter for the shared SoC MMIO bus.
// Grants ownership with a bounded burst, drives the shared bus from the owner,
// registers the region of each accepted read and routes the one-cycle-latency
// read data back to the master that issued it.
// Optional feature macro: MMIO_ARB_DECERR_EN (sticky dec_err flag and
// 32'hDEAD_BEEF read data for unmapped accesses).
//
// Handshake: a master holds mX_req (with addr/wdata/we/mask stable) until the
// beat is accepted; a beat is accepted at every posedge where mX_req & mX_gnt.
// Read data for an accepted read is valid for exactly the one cycle following
// acceptance, qualified by mX_rvalid; there is no back-pressure on returns.
module mmio_bus_arbiter #(
  parameter int          MAX_BURST = 8,
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] BRAM_TOP  = 32'h0000_07FF,
  parameter logic [31:0] GPIO_BASE = 32'hFFFF_FFF0,
  parameter logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_mask,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_mask,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_mask,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] gpio_rdata,
  output logic        dec_err,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } ownerT;

  typedef enum logic [1:0] {
    RG_NONE = 2'd0,
    RG_BRAM = 2'd1,
    RG_GPIO = 2'd2
  } regionT;

  localparam logic [8:0] MAX_CNT = 9'(MAX_BURST);

`ifdef MMIO_ARB_DECERR_EN
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_DATA = 32'h0000_0000;
`endif

  ownerT       ownerQ, ownerD;
  logic        lastWinnerQ, lastWinnerD;
  logic [7:0]  beatCntQ, beatCntD;
  logic        rdPendQ;
  logic        rdMasterQ;
  regionT      rdRegionQ;

  logic        curIdx;
  logic        curReq;
  logic        othReq;
  logic        accept;
  logic        readAccept;
  logic [8:0]  cntInc;
  regionT      busRegion;
  logic [31:0] regionData;

  // Owner index and request view, so both OWN states share one rule set.
  assign curIdx     = (ownerQ == OWN1);
  assign curReq     = curIdx ? m1_req : m0_req;
  assign othReq     = curIdx ? m0_req : m1_req;
  assign accept     = (ownerQ != IDLE) && curReq;
  assign readAccept = accept && !bus_we;
  assign cntInc     = {1'b0, beatCntQ} + 9'd1;

  // Next owner, tie-break memory and burst counter.
  always_comb begin
    ownerD      = ownerQ;
    lastWinnerD = lastWinnerQ;
    beatCntD    = beatCntQ;
    case (ownerQ)
      IDLE: begin
        beatCntD = 8'd0;
        if (m0_req && m1_req) begin
          // Tie: the master that did not win last time takes the bus.
          ownerD      = lastWinnerQ ? OWN0 : OWN1;
          lastWinnerD = !lastWinnerQ;
        end else if (m0_req) begin
          ownerD      = OWN0;
          lastWinnerD = 1'b0;
        end else if (m1_req) begin
          ownerD      = OWN1;
          lastWinnerD = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (curReq) begin
          // Burst exhausted (or already saturated) and the other side waits.
          if ((cntInc >= MAX_CNT) && othReq) begin
            ownerD      = curIdx ? OWN0 : OWN1;
            lastWinnerD = !curIdx;
            beatCntD    = 8'd0;
          end else if (cntInc >= MAX_CNT) begin
            beatCntD = MAX_CNT[7:0];
          end else begin
            beatCntD = cntInc[7:0];
          end
        end else begin
          beatCntD = 8'd0;
          if (othReq) begin
            ownerD      = curIdx ? OWN0 : OWN1;
            lastWinnerD = !curIdx;
          end else begin
            ownerD = IDLE;
          end
        end
      end
      default: begin
        ownerD   = IDLE;
        beatCntD = 8'd0;
      end
    endcase
  end

  // Arbitration and read-return state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ownerQ      <= IDLE;
      lastWinnerQ <= 1'b1;
      beatCntQ    <= 8'd0;
      rdPendQ     <= 1'b0;
      rdMasterQ   <= 1'b0;
      rdRegionQ   <= RG_NONE;
    end else begin
      ownerQ      <= ownerD;
      lastWinnerQ <= lastWinnerD;
      beatCntQ    <= beatCntD;
      rdPendQ     <= readAccept;
      if (readAccept) begin
        rdMasterQ <= curIdx;
        rdRegionQ <= busRegion;
      end
    end
  end

  // Shared bus driven from the current owner; all zero while idle.
  always_comb begin
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_mask  = 4'h0;
    bus_we    = 1'b0;
    if (ownerQ == OWN0) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_mask  = m0_mask;
      bus_we    = m0_we & m0_req;
    end else if (ownerQ == OWN1) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_mask  = m1_mask;
      bus_we    = m1_we & m1_req;
    end
  end

  // Region decode; offset compares keep the bounds check wrap-safe.
  always_comb begin
    busRegion = RG_NONE;
    if ((bus_addr - BRAM_BASE) <= (BRAM_TOP - BRAM_BASE)) begin
      busRegion = RG_BRAM;
    end else if ((bus_addr - GPIO_BASE) <= (GPIO_TOP - GPIO_BASE)) begin
      busRegion = RG_GPIO;
    end
  end

  // Read-data mux selected by the region captured at acceptance.
  always_comb begin
    regionData = UNMAPPED_DATA;
    case (rdRegionQ)
      RG_BRAM: regionData = bram_rdata;
      RG_GPIO: regionData = gpio_rdata;
      default: regionData = UNMAPPED_DATA;
    endcase
  end

  // A return that coincides with reset is suppressed, not delivered late.
  assign m0_gnt    = (ownerQ == OWN0);
  assign m1_gnt    = (ownerQ == OWN1);
  assign m0_rvalid = rdPendQ && reset_n && !rdMasterQ;
  assign m1_rvalid = rdPendQ && reset_n && rdMasterQ;
  assign m0_rdata  = m0_rvalid ? regionData : 32'h0;
  assign m1_rdata  = m1_rvalid ? regionData : 32'h0;
  assign dbgState  = ownerQ;

`ifdef MMIO_ARB_DECERR_EN
  logic decErrQ;

  // Sticky flag for any accepted beat that decodes to no slave.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      decErrQ <= 1'b0;
    end else if (accept && (busRegion == RG_NONE)) begin
      decErrQ <= 1'b1;
    end
  end

  assign dec_err = decErrQ;
`else
  assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter with simple BRAM/GPIO slave models.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_mask;
  logic [31:0] bram_rdata, gpio_rdata;
  logic        dec_err;
  logic [1:0]  dbgState;

  logic [31:0] bram_mem [0:511];
  logic [31:0] gpio_val;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         cyc_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  // slave models: registered read data, one cycle after address
  always @(posedge clk) begin
    bram_rdata <= bram_mem[bus_addr[10:2]];
    gpio_rdata <= gpio_val;
  end

  mmio_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_mask(bus_mask),
    .bram_rdata(bram_rdata), .gpio_rdata(gpio_rdata), .dec_err(dec_err),
    .dbgState(dbgState)
  );

  // driver tasks
  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_we = 1'b0; m0_mask = 4'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_we = 1'b0; m1_mask = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got %b%b want 00", m1_gnt, m0_gnt); end
    total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b%b want 00", m1_rvalid, m0_rvalid); end
    total++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h %h want 0", m0_rdata, m1_rdata); end
    total++; if (bus_addr !== 32'h0 || bus_we !== 1'b0 || bus_mask !== 4'h0 || bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus got addr=%h we=%b want 0", bus_addr, bus_we); end
    total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL reset_dec_err got %b want 0", dec_err); end
    total++; if (dbgState !== 2'd0) begin bad++; $display("FAIL reset_state got %0d want 0", dbgState); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bram_mem[1] = 32'h1234_5678;
    m0_req = 1'b1; m0_addr = 32'h0000_0004; m0_we = 1'b0; m0_mask = 4'hF;
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL rd_grant got %b%b want 01", m1_gnt, m0_gnt); end
    total++; if (bus_addr !== 32'h0000_0004 || bus_we !== 1'b0) begin bad++; $display("FAIL rd_bus got addr=%h we=%b want 00000004/0", bus_addr, bus_we); end
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early_rvalid got %b want 0", m0_rvalid); end
    @(negedge clk);
    m0_req = 1'b0;
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_return got v=%b d=%h want 1/12345678", m0_rvalid, m0_rdata); end
    total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_other got v=%b d=%h want 0/0", m1_rvalid, m1_rdata); end
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL rd_pulse got %b want 0", m0_rvalid); end
    total++; if (m0_gnt !== 1'b0 || bus_addr !== 32'h0 || bus_we !== 1'b0 || dbgState !== 2'd0) begin bad++; $display("FAIL drop_idle got gnt=%b addr=%h we=%b st=%0d want 0", m0_gnt, bus_addr, bus_we, dbgState); end
  endtask

  task automatic test_burst();
    int sent0 = 0;
    int sent1 = 0;
    int cyc = 0;
    logic a0, a1;
    exp_q.delete(); got_q.delete(); cyc_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    m0_req = 1'b1; m0_we = 1'b1; m0_mask = 4'hF; m0_addr = 32'h0; m0_wdata = 32'hA000_0000;
    m1_req = 1'b1; m1_we = 1'b1; m1_mask = 4'h3; m1_addr = 32'h100; m1_wdata = 32'hB000_0000;
    while ((sent0 < 20 || sent1 < 20) && cyc < 300) begin
      a0 = m0_req & m0_gnt;
      a1 = m1_req & m1_gnt;
      @(negedge clk);
      cyc++;
      if (a0) begin
        got_q.push_back(1'b0); cyc_q.push_back(cyc); sent0++;
        if (sent0 == 20) m0_req = 1'b0;
        else begin m0_addr = 32'(sent0 * 4); m0_wdata = 32'hA000_0000 + 32'(sent0); end
      end
      if (a1) begin
        got_q.push_back(1'b1); cyc_q.push_back(cyc); sent1++;
        if (sent1 == 20) m1_req = 1'b0;
        else begin m1_addr = 32'h100 + 32'(sent1 * 4); m1_wdata = 32'hB000_0000 + 32'(sent1); end
      end
    end
    total++; if (cyc >= 300) begin bad++; $display("FAIL burst_timeout got sent0=%0d sent1=%0d want 20/20", sent0, sent1); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL burst_count got %0d want %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; k < 40; k++) begin
        total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL burst_order beat %0d got m%0d want m%0d", k, got_q[k], exp_q[k]); end
      end
      total++; if (cyc_q[0] != 2) begin bad++; $display("FAIL burst_first got cycle %0d want 2", cyc_q[0]); end
      for (int k = 1; k < 36; k++) begin
        total++; if (cyc_q[k] != cyc_q[0] + k) begin bad++; $display("FAIL burst_gap beat %0d got cycle %0d want %0d", k, cyc_q[k], cyc_q[0] + k); end
      end
      total++; if (cyc_q[36] != cyc_q[35] + 2) begin bad++; $display("FAIL burst_handoff got cycle %0d want %0d", cyc_q[36], cyc_q[35] + 2); end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bram_mem[3] = 32'hCAFE_0011;
    gpio_val = 32'h0000_0003;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_000C; m1_mask = 4'hF;
    @(negedge clk);
    while (!m1_gnt && n < 10) begin @(negedge clk); n++; end
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL b2b_grant got %b want 1", m1_gnt); end
    @(negedge clk);
    m1_addr = 32'hFFFF_FFF0;
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hCAFE_0011) begin bad++; $display("FAIL b2b_bram got v=%b d=%h want 1/cafe0011", m1_rvalid, m1_rdata); end
    total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL b2b_other got v=%b d=%h want 0/0", m0_rvalid, m0_rdata); end
    @(negedge clk);
    m1_req = 1'b0;
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0000_0003) begin bad++; $display("FAIL b2b_gpio got v=%b d=%h want 1/00000003", m1_rvalid, m1_rdata); end
    @(negedge clk);
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end got %b want 0", m1_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    int n = 0;
    logic [31:0] exp_d;
    logic        exp_e;
`ifdef MMIO_ARB_DECERR_EN
    exp_d = 32'hDEAD_BEEF; exp_e = 1'b1;
`else
    exp_d = 32'h0; exp_e = 1'b0;
`endif
    bram_mem[0] = 32'h5555_AAAA;
    gpio_val = 32'h7777_0000;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000; m0_mask = 4'hF;
    @(negedge clk);
    while (!m0_gnt && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    m0_req = 1'b0;
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d) begin bad++; $display("FAIL unmapped_data got v=%b d=%h want 1/%h", m0_rvalid, m0_rdata, exp_d); end
    total++; if (dec_err !== exp_e) begin bad++; $display("FAIL unmapped_flag got %b want %b", dec_err, exp_e); end
    repeat (3) @(negedge clk);
    total++; if (dec_err !== exp_e) begin bad++; $display("FAIL unmapped_sticky got %b want %b", dec_err, exp_e); end
  endtask

  task automatic test_hold();
    int sent = 0;
    int cyc = 0;
    int first = 0;
    int last = 0;
    logic a0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1; m0_mask = 4'hF;
    while (sent < 12 && cyc < 60) begin
      a0 = m0_req & m0_gnt;
      @(negedge clk);
      cyc++;
      if (a0) begin
        sent++;
        if (sent == 1) first = cyc;
        last = cyc;
        if (sent == 12) m0_req = 1'b0;
        else m0_addr = 32'h40 + 32'(sent * 4);
      end
    end
    total++; if (sent != 12) begin bad++; $display("FAIL hold_count got %0d want 12", sent); end
    total++; if (last - first != 11) begin bad++; $display("FAIL hold_stream got span %0d want 11", last - first); end
    @(negedge clk);
  endtask

  task automatic test_reset_drop();
    int n = 0;
    bram_mem[1] = 32'h1234_5678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0004; m0_mask = 4'hF;
    @(negedge clk);
    while (!m0_gnt && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    reset_n = 1'b0;
    m0_req = 1'b0;
    #1;
    total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL rst_drop_rvalid got v=%b d=%h want 0/0", m0_rvalid, m0_rdata); end
    @(negedge clk);
    total++; if (m0_gnt !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0) begin bad++; $display("FAIL rst_drop_bus got gnt=%b we=%b addr=%h want 0", m0_gnt, bus_we, bus_addr); end
    total++; if (m0_rvalid !== 1'b0 || dec_err !== 1'b0) begin bad++; $display("FAIL rst_drop_state got v=%b err=%b want 0/0", m0_rvalid, dec_err); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // scenario sequence and final report
  initial begin
    for (int i = 0; i < 512; i++) bram_mem[i] = 32'h0;
    gpio_val = 32'h0;
    test_reset();
    test_single_read();
    do_reset();
    test_burst();
    test_back_to_back();
    test_unmapped();
    test_hold();
    test_reset_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
